// File: rtl/mod_n_down_counter_pkg.sv
// Shared definitions for the modulo-N down counter:
// state encoding and the load-value clamp.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COUNT   = 2'b01,
      EXPIRED = 2'b10
   } state_t;

   function automatic int unsigned clamp(
      input int unsigned v,
      input int unsigned hi
   );
      return (v > hi) ? hi : v;
   endfunction

endpackage

// File: rtl/mod_n_down_counter_if.sv
// Control/status bundle of the modulo-N down counter.
// The master drives controls, the slave returns count and flags.
interface mod_n_down_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             start;
   logic             load;
   logic [WIDTH-1:0] d;
   logic             oneshot;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             done;
   logic             busy;

   modport master (
      output en, start, load, d, oneshot,
      input  q, tc, done, busy
   );

   modport slave (
      input  en, start, load, d, oneshot,
      output q, tc, done, busy
   );
endinterface

// File: rtl/mod_n_down_counter.sv
// Loadable modulo-N down counter with free-run/one-shot modes,
// combinational borrow (tc) for cascading and a sticky done flag.
import counter_pkg::*;

module mod_n_down_counter #(
   parameter int MOD   = 8,
   parameter int WIDTH = 3
) (
   input logic              clk,
   input logic              rst_n,
   mod_n_down_counter_if.slave bus
);

   localparam int unsigned    QMAX_I = MOD - 1;
   localparam logic [WIDTH-1:0] QMAX = WIDTH'(QMAX_I);

   state_t           state, state_n;
   logic [WIDTH-1:0] q, q_n;
   logic             done, done_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         q     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         q     <= q_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      q_n     = q;
      done_n  = done;
      if (bus.load) begin
         q_n     = WIDTH'(clamp(32'(bus.d), QMAX_I));
         state_n = COUNT;
         done_n  = 1'b0;
      end else if (bus.start && state != COUNT) begin
         q_n     = QMAX;
         state_n = COUNT;
         done_n  = 1'b0;
      end else if (state == COUNT && bus.en) begin
         // wrap at MOD, not 2**WIDTH
         if (q != '0) begin
            q_n = q - 1'b1;
         end else if (!bus.oneshot) begin
            q_n = QMAX;
         end else begin
            state_n = EXPIRED;
            done_n  = 1'b1;
         end
      end
   end

   assign bus.q    = q;
   assign bus.done = done;
   assign bus.busy = (state == COUNT);
   assign bus.tc   = (state == COUNT) & bus.en & (q == '0);

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed bench: free-run, one-shot, clamp, priority,
// async reset and a two-stage cascade.
module tb_mod_n_down_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mod_n_down_counter_if #(.WIDTH(3)) ia ();
   mod_n_down_counter_if #(.WIDTH(3)) ib ();
   mod_n_down_counter_if #(.WIDTH(3)) il ();
   mod_n_down_counter_if #(.WIDTH(3)) ih ();

   mod_n_down_counter #(.MOD(8), .WIDTH(3)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ia.slave));
   mod_n_down_counter #(.MOD(5), .WIDTH(3)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ib.slave));
   mod_n_down_counter #(.MOD(8), .WIDTH(3)) u_l (
      .clk(clk), .rst_n(rst_n), .bus(il.slave));
   mod_n_down_counter #(.MOD(8), .WIDTH(3)) u_h (
      .clk(clk), .rst_n(rst_n), .bus(ih.slave));

   assign ih.en = il.tc;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      ia.en = 1'b1; ia.start = 1'b0; ia.load = 1'b0;
      ia.d = '0; ia.oneshot = 1'b0;
      ib.en = 1'b0; ib.start = 1'b0; ib.load = 1'b0;
      ib.d = '0; ib.oneshot = 1'b0;
      il.en = 1'b0; il.start = 1'b0; il.load = 1'b0;
      il.d = '0; il.oneshot = 1'b0;
      ih.start = 1'b0; ih.load = 1'b0;
      ih.d = '0; ih.oneshot = 1'b0;

      // reset state
      #12;
      chk("rst_q", 32'(ia.q), 0);
      chk("rst_busy", 32'(ia.busy), 0);
      chk("rst_done", 32'(ia.done), 0);
      chk("rst_tc", 32'(ia.tc), 0);
      rst_n = 1'b1;

      // 1: free-run 7..0,7
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      #1;
      chk("fr_q0", 32'(ia.q), 7);
      chk("fr_busy0", 32'(ia.busy), 1);
      chk("fr_tc0", 32'(ia.tc), 0);
      for (int i = 1; i <= 7; i++) begin
         tick(); #1;
         chk("fr_q", 32'(ia.q), 32'(7 - i));
         chk("fr_tc", 32'(ia.tc), (i == 7) ? 1 : 0);
         chk("fr_busy", 32'(ia.busy), 1);
      end
      tick(); #1;
      chk("fr_wrap", 32'(ia.q), 7);
      chk("fr_wrap_tc", 32'(ia.tc), 0);

      // 2: one-shot from load 3
      ia.load = 1'b1; ia.d = 3'd3; ia.oneshot = 1'b1;
      tick();
      ia.load = 1'b0;
      #1;
      chk("os_q3", 32'(ia.q), 3);
      chk("os_done0", 32'(ia.done), 0);
      for (int i = 2; i >= 0; i--) begin
         tick(); #1;
         chk("os_q", 32'(ia.q), 32'(i));
         chk("os_tc", 32'(ia.tc), (i == 0) ? 1 : 0);
      end
      tick(); #1;
      chk("os_hold", 32'(ia.q), 0);
      chk("os_done", 32'(ia.done), 1);
      chk("os_busy", 32'(ia.busy), 0);
      chk("os_tc_off", 32'(ia.tc), 0);
      tick(); #1;
      chk("os_hold2", 32'(ia.q), 0);
      chk("os_done2", 32'(ia.done), 1);

      // 4: load beats start and count
      ia.oneshot = 1'b0;
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      #1;
      chk("pr_start", 32'(ia.q), 7);
      chk("pr_done_clr", 32'(ia.done), 0);
      repeat (5) tick();
      #1;
      chk("pr_q2", 32'(ia.q), 2);
      ia.load = 1'b1; ia.start = 1'b1; ia.d = 3'd6;
      tick();
      ia.load = 1'b0; ia.start = 1'b0;
      #1;
      chk("pr_load", 32'(ia.q), 6);
      chk("pr_done", 32'(ia.done), 0);
      ia.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("pr_hold", 32'(ia.q), 6);
         chk("pr_hold_tc", 32'(ia.tc), 0);
      end

      // 3: MOD=5 clamp and wrap
      ib.load = 1'b1; ib.d = 3'd7; ib.en = 1'b1;
      tick();
      ib.load = 1'b0;
      #1;
      chk("cl_q4", 32'(ib.q), 4);
      for (int i = 3; i >= 0; i--) begin
         tick(); #1;
         chk("cl_q", 32'(ib.q), 32'(i));
      end
      chk("cl_tc", 32'(ib.tc), 1);
      tick(); #1;
      chk("cl_wrap", 32'(ib.q), 4);
      ib.en = 1'b0;

      // 6: cascade 63..0 then wrap
      il.start = 1'b1; ih.start = 1'b1; il.en = 1'b1;
      tick();
      il.start = 1'b0; ih.start = 1'b0;
      #1;
      chk("cas_63", 32'({ih.q, il.q}), 63);
      for (int k = 1; k <= 64; k++) begin
         tick(); #1;
         chk("cas", 32'({ih.q, il.q}), 32'((127 - k) % 64));
      end
      il.en = 1'b0;

      // 5: async reset mid-count
      ia.en = 1'b1;
      tick(); tick(); #1;
      chk("ar_q4", 32'(ia.q), 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_q", 32'(ia.q), 0);
      chk("ar_busy", 32'(ia.busy), 0);
      chk("ar_done", 32'(ia.done), 0);
      chk("ar_tc", 32'(ia.tc), 0);
      #1;
      rst_n = 1'b1;
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      #1;
      chk("ar_restart", 32'(ia.q), 7);
      chk("ar_busy1", 32'(ia.busy), 1);
      tick(); #1;
      chk("ar_dec", 32'(ia.q), 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_n_down_counter.md
Name: mod_n_down_counter

Overview:
Loadable modulo-N down counter. It is the count-down counterpart of the team's mod-8 up counter. It counts from a start or loaded value toward 0, then either wraps to MOD-1 (free-run) or stops and flags completion (one-shot). It produces a combinational borrow/terminal-count output for cascading, and is used as a timeout/interval timer beside the up counters.

Parameters:
MOD, 8, counter modulus; legal range 2..2**WIDTH; count range 0..MOD-1
WIDTH, 3, width of q and d; must satisfy 2**WIDTH >= MOD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  count enable; decrement only when high
start  input  1  begin counting from MOD-1; honoured in IDLE and EXPIRED only
load  input  1  parallel load of d; honoured in any state
d  input  WIDTH  load value
oneshot  input  1  0 = wrap at 0, 1 = stop at 0; sampled every cycle
q  output  WIDTH  current count, registered
tc  output  1  terminal count/borrow, combinational
done  output  1  sticky one-shot completion flag, registered
busy  output  1  high while in COUNT, registered state decode

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: on rst_n=0, immediately (no clock needed) q=0, done=0, busy=0, state=IDLE. tc=0 because it decodes state. Release is synchronous to the next clk edge.
- States: IDLE, COUNT, EXPIRED (2-bit encoding).
- Priority each edge: reset > load > start > count.
- load=1, any state:
  - q <= d, clamped to MOD-1 if d > MOD-1.
  - state <= COUNT, done <= 0.
  - en is ignored that cycle; no decrement.
- start=1, load=0, state IDLE or EXPIRED:
  - q <= MOD-1, state <= COUNT, done <= 0.
  - start is ignored in COUNT.
- COUNT, en=0: hold q and state.
- COUNT, en=1, q!=0: q <= q-1.
- COUNT, en=1, q==0, oneshot=0: q <= MOD-1; stay in COUNT.
- COUNT, en=1, q==0, oneshot=1: q holds 0; state <= EXPIRED; done <= 1.
- IDLE and EXPIRED: q holds. done stays until load, start or reset.
- tc = (state==COUNT) & en & (q==0). It is combinational, with zero latency from en, and is the borrow into a cascaded higher stage.
- busy = (state==COUNT).
- Arithmetic: decrement modulo MOD, not 2**WIDTH. q must never take a value above MOD-1.
- Latency: q after load/start is visible 1 cycle later. A free-run period is MOD enabled cycles per tc pulse.
- Reset mid-count: state is lost and the block returns to IDLE; the last count is not retained.
- oneshot changed mid-count: it takes effect at the next q==0 decision. No other effect.

Decomposition:
- Shared package (counter_pkg): state encoding constants IDLE=2'b00, COUNT=2'b01, EXPIRED=2'b10; a clamp function for load values.
- No sub-module. Next-state/next-q logic and the registers stay in one module.
- For cascading, the integrator instantiates two copies and ties the upper stage's en to the lower stage's tc.

Test Plan:
1. Reset, then start=1 for 1 cycle, en=1, oneshot=0 -> q goes 7,6,5,...,0,7. tc=1 only in the q=0 cycle. busy=1 throughout.
2. load=1 with d=3, then en=1, oneshot=1 -> q=3,2,1,0, then holds 0. done=1 and busy=0 from the edge after q=0. tc high for exactly 1 cycle.
3. MOD=5, WIDTH=3, load d=7 -> q=4 (clamped). Free-run gives 4,3,2,1,0,4; q never shows 5..7.
4. During COUNT at q=2: load=1, start=1 and en=1 in the same cycle with d=6 -> next q=6, no decrement, done=0. Then toggle en=0 for 3 cycles -> q holds 6 and tc stays 0.
5. rst_n low asynchronously between edges mid-count (q=4) -> q=0, busy=0, done=0 immediately. start after release -> counting resumes from 7.
6. Two instances with MOD=8 cascaded (hi.en = lo.tc) -> after start on both, hi decrements once per 8 lo cycles. The combined value steps 63 down to 0 over 64 cycles.
